// File: rtl/det_seq_ctrl.sv
// Sequencing controller for the serial 1001/111 detector: arbitrates two word
// requesters, serializes the granted word MSB-first and returns the hit count.
// Optional build macro: DET_SEQ_FIXED_PRI_EN (fixed priority, requester 0 wins ties).
module det_seq_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0,
  input  logic [WORD_W-1:0] data0,
  input  logic              req1,
  input  logic [WORD_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic [CNT_W-1:0]  hits,
  output logic              busy,
  output logic              det_w,
  output logic              det_rst,
  input  logic              det_z
);

  localparam int unsigned BIT_CNT_W = $clog2(WORD_W + 1);
  localparam logic [BIT_CNT_W-1:0] BITS_FULL = BIT_CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0]     HIT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [WORD_W-1:0]    sreg, sreg_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]     hit_cnt, hit_cnt_nxt;
  logic [CNT_W-1:0]     hits_nxt;
  logic                 gnt, gnt_nxt;
  logic                 ack0_nxt, ack1_nxt;
  logic                 busy_nxt, det_w_nxt, det_rst_nxt;
  logic                 pick1_c;
  logic [CNT_W-1:0]     hit_sat_c;

  // Requester selection used when leaving IDLE
`ifdef DET_SEQ_FIXED_PRI_EN
  assign pick1_c = ~req0;
`else
  logic last;

  assign pick1_c = (req0 & req1) ? ~last : req1;

  // Round-robin pointer: identity of the requester served most recently
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      last <= 1'b1;
    end else if (state == S_DONE) begin
      last <= gnt;
    end
  end
`endif

  // Hit counter increment that sticks at the maximum instead of wrapping
  assign hit_sat_c = (det_z && (hit_cnt != HIT_MAX)) ? hit_cnt + CNT_W'(1) : hit_cnt;

  // State, datapath and output registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= S_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      hit_cnt <= '0;
      gnt     <= 1'b0;
      hits    <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
      det_w   <= 1'b0;
      det_rst <= 1'b1;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      hit_cnt <= hit_cnt_nxt;
      gnt     <= gnt_nxt;
      hits    <= hits_nxt;
      ack0    <= ack0_nxt;
      ack1    <= ack1_nxt;
      busy    <= busy_nxt;
      det_w   <= det_w_nxt;
      det_rst <= det_rst_nxt;
    end
  end

  // Next state and next registered output values
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    hit_cnt_nxt = hit_cnt;
    gnt_nxt     = gnt;
    hits_nxt    = hits;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    det_w_nxt   = 1'b0;
    det_rst_nxt = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_nxt     = pick1_c;
          sreg_nxt    = pick1_c ? data1 : data0;
          bit_cnt_nxt = BITS_FULL;
          hit_cnt_nxt = '0;
          det_rst_nxt = 1'b1;
          state_nxt   = S_CLR;
        end
      end
      S_CLR: begin
        // First bit leaves as the detector comes out of clear
        det_w_nxt   = sreg[WORD_W-1];
        sreg_nxt    = sreg << 1;
        bit_cnt_nxt = bit_cnt - BIT_CNT_W'(1);
        state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        hit_cnt_nxt = hit_sat_c;
        if (bit_cnt == '0) begin
          state_nxt = S_DRAIN;
        end else begin
          det_w_nxt   = sreg[WORD_W-1];
          sreg_nxt    = sreg << 1;
          bit_cnt_nxt = bit_cnt - BIT_CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // z of the final bit arrives here; publish result alongside ack
        hit_cnt_nxt = hit_sat_c;
        hits_nxt    = hit_sat_c;
        ack0_nxt    = ~gnt;
        ack1_nxt    = gnt;
        state_nxt   = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
